// File: rtl/vga_timing_pkg.sv
// ============================================================================
// vga_timing_pkg -- 640x480@60 timing constants, FSM/phase enums, phase decode
// rev 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    // Everything past active+front+sync is back porch; the total bounds the counter.
    function automatic phase_t axis_phase(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] act_len,
        input logic [CNT_W-1:0] front_len,
        input logic [CNT_W-1:0] sync_len
    );
        logic [CNT_W-1:0] front_end;
        logic [CNT_W-1:0] sync_end;
        front_end = act_len + front_len;
        sync_end  = front_end + sync_len;
        if (cnt < act_len)        return ACTIVE;
        else if (cnt < front_end) return FRONT;
        else if (cnt < sync_end)  return SYNC;
        else                      return BACK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// vga_axis_counter -- one raster axis: wrapping counter, next value, phase of next
// rev 1.0
// ============================================================================
`default_nettype none

module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE_LEN = 640,
    parameter int FRONT_LEN  = 16,
    parameter int SYNC_LEN   = 96,
    parameter int BACK_LEN   = 48
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_d_o,
    output logic             wrap_o,
    output logic [1:0]       phase_d_o
);

    localparam logic [CNT_W-1:0] LAST =
        CNT_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    assign wrap = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Phase follows the next value so registered syncs line up with the count.
    assign phase_d_o = axis_phase(cnt_d, CNT_W'(ACTIVE_LEN), CNT_W'(FRONT_LEN),
                                  CNT_W'(SYNC_LEN));
    assign cnt_o     = cnt_q;
    assign cnt_d_o   = cnt_d;
    assign wrap_o    = wrap;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen -- VGA raster timing: DrawX/DrawY, blank, hs/vs, frame strobe
// Optional frame counter: define VGA_FRAME_CNT_EN.              rev 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FRONT  = VGA_H_FRONT,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BACK   = VGA_H_BACK,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FRONT  = VGA_V_FRONT,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BACK   = VGA_V_BACK
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    ctrl_state_t state_q;
    logic        blank_q;
    logic        hs_q;
    logic        vs_q;
    logic        frame_start_q;

    logic [CNT_W-1:0] x_d;
    logic [CNT_W-1:0] y_d;
    logic             h_en;
    logic             h_wrap;
    logic             v_wrap;
    logic [1:0]       h_phase_d;
    logic [1:0]       v_phase_d;

    assign h_en = (state_q == RUN);

    vga_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE),
        .FRONT_LEN  (H_FRONT),
        .SYNC_LEN   (H_SYNC),
        .BACK_LEN   (H_BACK)
    ) u_h_axis (
        .clk_i     (vga_clk),
        .rst_n_i   (reset_n),
        .en_i      (h_en),
        .cnt_o     (DrawX),
        .cnt_d_o   (x_d),
        .wrap_o    (h_wrap),
        .phase_d_o (h_phase_d)
    );

    vga_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE),
        .FRONT_LEN  (V_FRONT),
        .SYNC_LEN   (V_SYNC),
        .BACK_LEN   (V_BACK)
    ) u_v_axis (
        .clk_i     (vga_clk),
        .rst_n_i   (reset_n),
        .en_i      (h_wrap),
        .cnt_o     (DrawY),
        .cnt_d_o   (y_d),
        .wrap_o    (v_wrap),
        .phase_d_o (v_phase_d)
    );

    // In IDLE the counters are held, so the decode of (0,0) yields the first-pixel outputs.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            blank_q       <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: state_q <= RUN;
                RUN:  state_q <= RUN;
            endcase
            blank_q       <= (h_phase_d == ACTIVE) && (v_phase_d == ACTIVE);
            hs_q          <= (h_phase_d != SYNC);
            vs_q          <= (v_phase_d != SYNC);
            frame_start_q <= (x_d == '0) && (y_d == '0);
        end
    end

    assign blank       = blank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            frame_cnt_q <= 8'd0;
        end else if (v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. Produces the DrawX/DrawY pixel coordinates, active-high `blank` (1 = visible pixel), active-low hsync/vsync and a frame-start strobe. It sits directly upstream of every sprite/ROM renderer (duck sprites, backgrounds), which consume DrawX, DrawY and blank on the same `vga_clk`.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- vga_clk  input  1  pixel clock, all logic on posedge
- reset_n  input  1  reset, synchronous, active-low
- DrawX  output  10  current pixel column, 0..H_TOTAL-1
- DrawY  output  10  current line, 0..V_TOTAL-1
- blank  output  1  1 when DrawX < H_ACTIVE and DrawY < V_ACTIVE
- hs  output  1  hsync, active-low
- vs  output  1  vsync, active-low
- frame_start  output  1  one-cycle strobe at pixel (0,0)
- frame_cnt  output  8  frame counter (see Configuration)

## Operation
- H_TOTAL = sum of H_* (800), V_TOTAL = sum of V_* (525); both must be ≤ 1024; all counter arithmetic is 10-bit unsigned.
- Control FSM: IDLE, RUN.
  - Any edge with reset_n=0: state ← IDLE; DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_start=0, frame_cnt=0.
  - IDLE, reset_n=1: → RUN; counters held at (0,0); blank←1, frame_start←1.
  - RUN: DrawX increments each clock; at DrawX=H_TOTAL-1 it wraps to 0 and DrawY increments; at (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
- Per-axis phase (ACTIVE, FRONT, SYNC, BACK), decoded from the counter:
  - hs=0 iff H_ACTIVE+H_FRONT ≤ DrawX < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - vs=0 iff V_ACTIVE+V_FRONT ≤ DrawY < V_ACTIVE+V_FRONT+V_SYNC (lines 490..491, all columns).
- frame_start=1 exactly in the cycle where DrawX=0 and DrawY=0 in RUN (including the first cycle after IDLE).
- Reset mid-frame aborts immediately; no partial-frame state survives.

## Timing
- All outputs are registered. hs, vs, blank and frame_start are computed from next-state counters, so they always describe the pixel currently on DrawX/DrawY (zero skew).
- First valid pixel: 1 clock after reset_n rises (IDLE→RUN edge), with (0,0), blank=1 and frame_start=1.
- Frame period: exactly 420,000 clocks; the frame_start interval equals that exactly.
- Downstream renderers read their ROM on negedge and register RGB on posedge, so they add 1 clock of latency. Sync outputs are not delayed here; the top level adds the matching 1-cycle delay on hs/vs.

## Configuration
- VGA_FRAME_CNT_EN defined: frame_cnt increments on the wrap edge (H_TOTAL-1, V_TOTAL-1)→(0,0) and wraps 255→0. It is 0 during the first frame after reset and does not increment on the IDLE→RUN edge.
- Undefined: frame_cnt is constant 0 and no counter register exists. The port remains present, so integration is identical.

## Structure
- `vga_timing_pkg`: default timing localparams, derived H_TOTAL/V_TOTAL, the `ctrl_state_t` enum (IDLE/RUN) and the `phase_t` enum (ACTIVE/FRONT/SYNC/BACK).
- One sub-module, `vga_axis_counter`: parameterised counter with wrap output and phase decode, instanced for horizontal (enable = RUN) and vertical (enable = horizontal wrap).

## Test plan
- Reset held for 5 clocks → DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_start=0, frame_cnt=0. One clock after release → (0,0), blank=1, frame_start=1.
- Line 0 scan → blank falls at DrawX=640; hs=0 for DrawX 656..751 (96 clocks); at DrawX=799→0, DrawY goes 0→1.
- Lines 480..524 → blank=0 throughout; vs=0 exactly for DrawY 490 and 491 (1600 clocks).
- Frame wrap at (799,524) → next cycle (0,0) with frame_start=1; frame_start spacing is 420,000 clocks; with the macro defined, frame_cnt goes 0→1.
- Reset asserted at (300,200) for 1 clock → idle values on the next edge. After release, restart at (0,0) with frame_start=1 and frame_cnt=0.
- With the macro, run 256 frames → frame_cnt wraps 255→0. Without the macro, frame_cnt=0 throughout.
